lamp_toggle_bank: RTL and testbench

Buffered lamp-state writer for the Wirelog gate fabric. It accepts wire-trigger events (one lamp index per event) through a valid/ready handshake, queues them in a small FIFO, and applies them one per cycle as toggles to a bank of lamp bits. The lamp bits drive the `in` vector of the multi-input gate modules. An `apply_en` gate lets the fabric freeze lamp state while gates evaluate.

---
 rtl/lamp_toggle_bank.sv | 132 +++++++++++++
 tb/tb_lamp_toggle_bank.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lamp_toggle_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lamp_toggle_bank                                              |
// | Purpose  : FIFO-buffered trigger queue that toggles a bank of lamp bits, |
// |            draining one event per cycle while apply_en is high.          |
// | Option   : LAMP_TOGGLE_BANK_STATS_EN adds a saturating toggle_count.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module lamp_toggle_bank #(
  parameter int LAMP_COUNT = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = (LAMP_COUNT > 1) ? $clog2(LAMP_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  logic_reset_n,
  input  logic                  clear,
  input  logic                  trig_valid,
  input  logic [IDX_W-1:0]      trig_idx,
  output logic                  trig_ready,
  input  logic                  apply_en,
  output logic [LAMP_COUNT-1:0] lamps,
  output logic                  changed,
  output logic                  drop,
  output logic                  busy
`ifdef LAMP_TOGGLE_BANK_STATS_EN
  ,
  output logic [15:0]           toggle_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [IDX_W-1:0]      fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic [LAMP_COUNT-1:0] lamps_q,  lamps_d;
  logic                  changed_q, changed_d;
  logic                  drop_q,    drop_d;

  logic [IDX_W-1:0]      w_head;
  logic [LAMP_COUNT-1:0] w_mask;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_in_range;

  // Ready and busy come from the registered count only, so a same-cycle pop
  // never opens a slot for the push being offered.
  assign trig_ready = (count_q < DEPTH_CNT);
  assign busy       = (count_q != '0);
  assign lamps      = lamps_q;
  assign changed    = changed_q;
  assign drop       = drop_q;

  always_comb begin
    w_head     = fifo_q[rd_ptr_q];
    w_push     = trig_valid && trig_ready && !clear;
    w_pop      = apply_en && (count_q != '0) && !clear;
    w_in_range = (32'(w_head) < 32'(LAMP_COUNT));
    w_mask     = '0;
    for (int i = 0; i < LAMP_COUNT; i++) begin
      w_mask[i] = (32'(w_head) == 32'(i));
    end

    wr_ptr_d  = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    lamps_d   = (w_pop && w_in_range) ? (lamps_q ^ w_mask) : lamps_q;
    changed_d = w_pop && w_in_range;
    drop_d    = w_pop && !w_in_range;

    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      lamps_d   = '0;
      changed_d = 1'b0;
      drop_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge logic_reset_n) begin
    if (!logic_reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      lamps_q   <= '0;
      changed_q <= 1'b0;
      drop_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      lamps_q   <= lamps_d;
      changed_q <= changed_d;
      drop_q    <= drop_d;
      if (w_push) begin
        fifo_q[wr_ptr_q] <= trig_idx;
      end
    end
  end

`ifdef LAMP_TOGGLE_BANK_STATS_EN
  logic [15:0] toggle_q, toggle_d;

  always_comb begin
    toggle_d = toggle_q;
    if (clear) begin
      toggle_d = '0;
    end else if (w_pop && w_in_range && (toggle_q != 16'hFFFF)) begin
      toggle_d = toggle_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge logic_reset_n) begin
    if (!logic_reset_n) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign toggle_count = toggle_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lamp_toggle_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_lamp_toggle_bank                                           |
// | Purpose  : Directed self-checking bench for lamp_toggle_bank.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_lamp_toggle_bank;

  logic       clk = 1'b0;
  logic       logic_reset_n;
  logic       clear;
  logic       apply_en;
  logic       trig_valid;
  logic [1:0] trig_idx;
  logic       trig_ready;
  logic [3:0] lamps;
  logic       changed, drop, busy;

  logic       trig_valid3;
  logic [1:0] trig_idx3;
  logic       trig_ready3;
  logic [2:0] lamps3;
  logic       changed3, drop3, busy3;

`ifdef LAMP_TOGGLE_BANK_STATS_EN
  logic [15:0] toggle_count;
  logic [15:0] toggle_count3;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lamp_toggle_bank #(.LAMP_COUNT(4), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .logic_reset_n(logic_reset_n), .clear(clear),
    .trig_valid(trig_valid), .trig_idx(trig_idx), .trig_ready(trig_ready),
    .apply_en(apply_en), .lamps(lamps), .changed(changed), .drop(drop),
    .busy(busy)
`ifdef LAMP_TOGGLE_BANK_STATS_EN
    , .toggle_count(toggle_count)
`endif
  );

  // Three lamps with a 2-bit index, so index 3 is representable but invalid.
  lamp_toggle_bank #(.LAMP_COUNT(3), .FIFO_DEPTH(4), .IDX_W(2)) u_dut3 (
    .clk(clk), .logic_reset_n(logic_reset_n), .clear(clear),
    .trig_valid(trig_valid3), .trig_idx(trig_idx3), .trig_ready(trig_ready3),
    .apply_en(apply_en), .lamps(lamps3), .changed(changed3), .drop(drop3),
    .busy(busy3)
`ifdef LAMP_TOGGLE_BANK_STATS_EN
    , .toggle_count(toggle_count3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic_reset_n = 1'b0;
    clear         = 1'b0;
    apply_en      = 1'b0;
    trig_valid    = 1'b0;
    trig_idx      = 2'd0;
    trig_valid3   = 1'b0;
    trig_idx3     = 2'd0;
    tick();
    tick();
    logic_reset_n = 1'b1;

    chk("rst_lamps", 32'(lamps), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(trig_ready), 32'h1);
    chk("rst_changed", 32'(changed), 32'h0);
    chk("rst_drop", 32'(drop), 32'h0);

    // Single trigger idx 2
    apply_en   = 1'b1;
    trig_valid = 1'b1;
    trig_idx   = 2'd2;
    tick();
    trig_valid = 1'b0;
    chk("single_busy_e1", 32'(busy), 32'h1);
    chk("single_lamps_e1", 32'(lamps), 32'h0);
    tick();
    chk("single_lamps_e2", 32'(lamps), 32'h4);
    chk("single_changed_e2", 32'(changed), 32'h1);
    chk("single_busy_e2", 32'(busy), 32'h0);
    tick();
    chk("single_changed_e3", 32'(changed), 32'h0);
    chk("single_lamps_e3", 32'(lamps), 32'h4);
`ifdef LAMP_TOGGLE_BANK_STATS_EN
    chk("single_stats", 32'(toggle_count), 32'h1);
`endif

    // Back-to-back idx 1 from a cleared bank
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_lamps", 32'(lamps), 32'h0);
    trig_valid = 1'b1;
    trig_idx   = 2'd1;
    tick();
    tick();
    trig_valid = 1'b0;
    chk("b2b_lamps_e2", 32'(lamps), 32'h2);
    chk("b2b_changed_e2", 32'(changed), 32'h1);
    chk("b2b_busy_e2", 32'(busy), 32'h1);
    tick();
    chk("b2b_lamps_e3", 32'(lamps), 32'h0);
    chk("b2b_changed_e3", 32'(changed), 32'h1);
    tick();
    chk("b2b_changed_e4", 32'(changed), 32'h0);
    chk("b2b_busy_e4", 32'(busy), 32'h0);

    // Full and hold
    apply_en   = 1'b0;
    trig_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      trig_idx = 2'(i);
      tick();
    end
    chk("full_ready", 32'(trig_ready), 32'h0);
    chk("full_busy", 32'(busy), 32'h1);
    chk("full_lamps_hold", 32'(lamps), 32'h0);
    trig_idx = 2'd0;
    tick();
    chk("full_ready_5th", 32'(trig_ready), 32'h0);
    trig_valid = 1'b0;
    apply_en   = 1'b1;
    tick();
    chk("drain_lamps_p1", 32'(lamps), 32'h1);
    chk("drain_ready_p1", 32'(trig_ready), 32'h1);
    tick();
    tick();
    tick();
    chk("drain_lamps_p4", 32'(lamps), 32'hF);
    chk("drain_busy_p4", 32'(busy), 32'h0);
    tick();
    tick();
    chk("drain_no_5th", 32'(lamps), 32'hF);
    chk("drain_changed_idle", 32'(changed), 32'h0);

    // Out of range on the three-lamp instance
    trig_valid3 = 1'b1;
    trig_idx3   = 2'd3;
    tick();
    trig_valid3 = 1'b0;
    chk("oor_busy_e1", 32'(busy3), 32'h1);
    tick();
    chk("oor_drop_e2", 32'(drop3), 32'h1);
    chk("oor_changed_e2", 32'(changed3), 32'h0);
    chk("oor_lamps_e2", 32'(lamps3), 32'h0);
    tick();
    chk("oor_drop_e3", 32'(drop3), 32'h0);
    trig_valid3 = 1'b1;
    trig_idx3   = 2'd2;
    tick();
    trig_valid3 = 1'b0;
    tick();
    chk("inr3_lamps", 32'(lamps3), 32'h4);
    chk("inr3_changed", 32'(changed3), 32'h1);
    chk("inr3_drop", 32'(drop3), 32'h0);

    // Clear with a simultaneous push
    clear = 1'b1;
    tick();
    clear      = 1'b0;
    trig_valid = 1'b1;
    trig_idx   = 2'd0;
    tick();
    trig_valid = 1'b0;
    tick();
    chk("cp_lamps_pre", 32'(lamps), 32'h1);
    apply_en   = 1'b0;
    trig_valid = 1'b1;
    trig_idx   = 2'd2;
    tick();
    trig_idx   = 2'd1;
    tick();
    chk("cp_busy_pre", 32'(busy), 32'h1);
    clear    = 1'b1;
    trig_idx = 2'd3;
    tick();
    clear      = 1'b0;
    trig_valid = 1'b0;
    chk("cp_lamps", 32'(lamps), 32'h0);
    chk("cp_busy", 32'(busy), 32'h0);
    chk("cp_ready", 32'(trig_ready), 32'h1);
`ifdef LAMP_TOGGLE_BANK_STATS_EN
    chk("cp_stats", 32'(toggle_count), 32'h0);
`endif
    apply_en = 1'b1;
    tick();
    tick();
    chk("cp_no_stale", 32'(lamps), 32'h0);
    chk("cp_changed", 32'(changed), 32'h0);

    // Asynchronous reset mid-drain with three entries still queued
    apply_en   = 1'b0;
    trig_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      trig_idx = 2'(i);
      tick();
    end
    trig_valid = 1'b0;
    apply_en   = 1'b1;
    tick();
    chk("mr_lamps_pre", 32'(lamps), 32'h1);
    chk("mr_changed_pre", 32'(changed), 32'h1);
    logic_reset_n = 1'b0;
    #1;
    chk("mr_lamps", 32'(lamps), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_ready", 32'(trig_ready), 32'h1);
    chk("mr_changed", 32'(changed), 32'h0);
    tick();
    logic_reset_n = 1'b1;
    tick();
    tick();
    tick();
    chk("mr_no_stale", 32'(lamps), 32'h0);
    chk("mr_changed_post", 32'(changed), 32'h0);
    chk("mr_busy_post", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
